// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-back/write-allocate cache line-array controller.
// Define CACHE_CTRL_STATS_EN to add the stat_hit/stat_miss counters.
module cache_ctrl_dm #(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 7,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_WIDTH  = (1 << OFFSET_WIDTH) * DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [31:0]                       cpu_addr,
  input  logic [3:0]                        cpu_byte_en,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  output logic [DATA_WIDTH-1:0]             cpu_rdata,
  output logic                              cpu_ready,
  output logic                              ln_enable,
  output logic                              ln_cmp,
  output logic                              ln_write,
  output logic                              ln_valid_in,
  output logic [3:0]                        ln_byte_w_en,
  output logic [TAG_WIDTH-1:0]              ln_tag,
  output logic [INDEX_WIDTH-1:0]            ln_index,
  output logic [OFFSET_WIDTH-1:0]           ln_word_sel,
  output logic [DATA_WIDTH-1:0]             ln_data_in,
  output logic [BLOCK_WIDTH-1:0]            ln_block_in,
  input  logic                              ln_hit,
  input  logic                              ln_dirty,
  input  logic                              ln_valid,
  input  logic [TAG_WIDTH-1:0]              ln_tag_out,
  input  logic [DATA_WIDTH-1:0]             ln_data_out,
  input  logic [BLOCK_WIDTH-1:0]            ln_data_wb,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  mem_addr,
  output logic [BLOCK_WIDTH-1:0]            mem_wdata,
  input  logic [BLOCK_WIDTH-1:0]            mem_rdata,
  input  logic                              mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                       stat_hit,
  output logic [31:0]                       stat_miss
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE,
    S_WB,
    S_REFILL,
    S_LOAD
  } state_t;

  state_t state, state_nx;

  logic                    req_we;
  logic [3:0]              req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_word;
  logic [BLOCK_WIDTH-1:0]  refill_buf;
  logic                    lookup_hit;
  logic [1:0]              unused_addr;

  assign unused_addr = cpu_addr[1:0];
  assign lookup_hit  = ln_hit & ln_valid;

  assign ln_tag      = req_tag;
  assign ln_index    = req_index;
  assign ln_word_sel = req_word;
  assign ln_data_in  = req_wdata;
  assign ln_block_in = refill_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      req_we     <= 1'b0;
      req_be     <= '0;
      req_wdata  <= '0;
      req_tag    <= '0;
      req_index  <= '0;
      req_word   <= '0;
      refill_buf <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state     <= state_nx;
      cpu_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_be    <= cpu_byte_en;
            req_wdata <= cpu_wdata;
            req_word  <= cpu_addr[OFFSET_WIDTH+1:2];
            req_index <=
              cpu_addr[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2];
            req_tag   <= cpu_addr[31:32-TAG_WIDTH];
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            if (!req_we) begin
              cpu_rdata <= ln_data_out;
              cpu_ready <= 1'b1;
            end
          end else if (ln_valid && ln_dirty) begin
            mem_wdata <= ln_data_wb;
            mem_addr  <= {ln_tag_out, req_index};
          end else begin
            mem_addr  <= {req_tag, req_index};
          end
        end
        S_WRITE: cpu_ready <= 1'b1;
        S_WB: begin
          if (mem_ack) mem_addr <= {req_tag, req_index};
        end
        S_REFILL: begin
          if (mem_ack) refill_buf <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    ln_enable    = 1'b0;
    ln_cmp       = 1'b0;
    ln_write     = 1'b0;
    ln_valid_in  = 1'b0;
    ln_byte_w_en = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_req) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        ln_enable = 1'b1;
        ln_cmp    = 1'b1;
        if (lookup_hit)
          state_nx = req_we ? S_WRITE : S_IDLE;
        else if (ln_valid && ln_dirty)
          state_nx = S_WB;
        else
          state_nx = S_REFILL;
      end
      S_WRITE: begin
        ln_enable    = 1'b1;
        ln_cmp       = 1'b1;
        ln_write     = 1'b1;
        ln_byte_w_en = req_be;
        state_nx     = S_IDLE;
      end
      S_WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nx = S_REFILL;
      end
      S_REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_LOAD;
      end
      S_LOAD: begin
        ln_enable   = 1'b1;
        ln_write    = 1'b1;
        ln_valid_in = 1'b1;
        state_nx    = S_LOOKUP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // replay marks the LOOKUP that follows a LOAD so it is not counted twice
  logic replay;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay    <= 1'b0;
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (state == S_LOAD)
        replay <= 1'b1;
      else if (state == S_IDLE)
        replay <= 1'b0;
      if (state == S_LOOKUP && !replay) begin
        if (lookup_hit) stat_hit  <= stat_hit + 32'd1;
        else            stat_miss <= stat_miss + 32'd1;
      end
    end
  end
`else
  // default build carries no statistics state
`endif

endmodule
